// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared types and encodings for the ULPI link controller.
//   state_e       - link FSM states
//   TXCMD_PFX     - command-code prefix of a transmit TX CMD byte
//   line_state_e  - RX CMD LineState field, bits [1:0]
//   rx_event_e    - RX CMD RxEvent field, bits [5:4]
package ulpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_CMD,
    ST_TX_DATA,
    ST_TX_STP,
    ST_RX_TURN,
    ST_RX_BUS
  } state_e;

  localparam logic [1:0] TXCMD_PFX = 2'b01;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_e;

  typedef enum logic [1:0] {
    RXEV_INACTIVE = 2'b00,
    RXEV_ACTIVE   = 2'b01,
    RXEV_HOSTDISC = 2'b10,
    RXEV_ERROR    = 2'b11
  } rx_event_e;

  // Transmit command byte: prefix, two reserved zero bits, then the PID nibble.
  function automatic logic [7:0] tx_cmd_byte(input logic [3:0] pid);
    return {TXCMD_PFX, 2'b00, pid};
  endfunction

endpackage

// File: rtl/ulpi_link_ctrl_if.sv
// ulpi_link_ctrl_if: ULPI PHY bus bundle.
//   ulpi_clk, ulpi_dir, ulpi_nxt, ulpi_data_in : PHY -> link
//   ulpi_data_out, ulpi_stp                      : link -> PHY
// master = link controller side, slave = PHY side.
interface ulpi_link_ctrl_if;
  import ulpi_pkg::*;

  logic       ulpi_clk;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [7:0] ulpi_data_in;
  logic [7:0] ulpi_data_out;
  logic       ulpi_stp;

  modport master (
    input  ulpi_clk, ulpi_dir, ulpi_nxt, ulpi_data_in,
    output ulpi_data_out, ulpi_stp
  );

  modport slave (
    output ulpi_clk, ulpi_dir, ulpi_nxt, ulpi_data_in,
    input  ulpi_data_out, ulpi_stp
  );
endinterface

// File: rtl/ulpi_edge_sync.sv
// ulpi_edge_sync: brings ulpi_clk into the clk domain and flags its rising edge.
//   clk, n_rst : system clock, async active-low reset
//   ulpi_clk   : PHY clock, asynchronous to clk
//   uce        : high for one clk cycle per ulpi_clk rising edge
module ulpi_edge_sync
  import ulpi_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic ulpi_clk,
  output logic uce
);
  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  always_comb begin
    meta_d = ulpi_clk;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Edge taken between two registered samples, after the two-flop synchronizer.
  assign uce = sync_q & ~prev_q;
endmodule

// File: rtl/ulpi_link_ctrl.sv
// ulpi_link_ctrl: ULPI link-side controller (one TX packet type, RX capture).
//   clk, n_rst          : system clock, async active-low reset
//   bus                 : ULPI PHY bus (master modport)
//   tx_start/tx_payload : send request, byte 0 in bits [7:0]
//   tx_busy/done/abort  : TX status level and completion/abort pulses
//   rx_valid/rx_data    : received byte strobe and data
//   rx_active/rx_err    : RxActive level, RxError pulse
//   rx_count            : saturating byte count of the current RX session
module ulpi_link_ctrl
  import ulpi_pkg::*;
#(
  parameter int         TX_BYTES = 66,
  parameter logic [3:0] TX_PID   = 4'h3,
  parameter int         CNT_W    = 10
) (
  input  logic                    clk,
  input  logic                    n_rst,
  ulpi_link_ctrl_if.master        bus,
  input  logic                    tx_start,
  input  logic [TX_BYTES*8-1:0]   tx_payload,
  output logic                    tx_busy,
  output logic                    tx_done,
  output logic                    tx_abort,
  output logic                    rx_valid,
  output logic [7:0]              rx_data,
  output logic                    rx_active,
  output logic                    rx_err,
  output logic [CNT_W-1:0]        rx_count
);
  localparam int IDX_W = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TX_BYTES - 1);

  logic uce;

  ulpi_edge_sync u_edge_sync (
    .clk      (clk),
    .n_rst    (n_rst),
    .ulpi_clk (bus.ulpi_clk),
    .uce      (uce)
  );

  state_e                state_q, state_d;
  logic                  pending_q, pending_d;
  logic                  busy_q, busy_d;
  logic                  turn_q, turn_d;       // one idle uce owed after RX
  logic [TX_BYTES*8-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            data_out_q, data_out_d;
  logic                  stp_q, stp_d;
  logic                  done_q, done_d, abort_q, abort_d;
  logic                  valid_q, valid_d, err_q, err_d;
  logic                  rx_active_q, rx_active_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic [CNT_W-1:0]      rx_count_q, rx_count_d;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    busy_d      = busy_q;
    turn_d      = turn_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    rx_active_d = rx_active_q;
    rx_data_d   = rx_data_q;
    rx_count_d  = rx_count_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    if (tx_start && !busy_q) begin
      pending_d = 1'b1;
      busy_d    = 1'b1;
    end

    if (uce) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.ulpi_dir) begin
            state_d    = ST_RX_TURN;
            rx_count_d = '0;
          end else if (turn_q) begin
            turn_d = 1'b0;
          end else if (pending_q) begin
            state_d   = ST_TX_CMD;
            pending_d = 1'b0;
            shift_d   = tx_payload;
            idx_d     = '0;
          end
        end
        ST_TX_CMD, ST_TX_DATA: begin
          if (bus.ulpi_dir) begin
            // PHY grabbed the bus: abandon the packet without a stop strobe.
            state_d    = ST_RX_TURN;
            abort_d    = 1'b1;
            busy_d     = 1'b0;
            rx_count_d = '0;
          end else if (bus.ulpi_nxt) begin
            if (state_q == ST_TX_CMD) begin
              state_d = ST_TX_DATA;
            end else begin
              shift_d = shift_q >> 8;
              idx_d   = idx_q + IDX_W'(1);
              if (idx_q == LAST_IDX) state_d = ST_TX_STP;
            end
          end
        end
        ST_TX_STP: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
        ST_RX_TURN: begin
          state_d = bus.ulpi_dir ? ST_RX_BUS : ST_IDLE;
        end
        ST_RX_BUS: begin
          if (!bus.ulpi_dir) begin
            state_d     = ST_IDLE;
            rx_active_d = 1'b0;
            turn_d      = 1'b1;
          end else if (!bus.ulpi_nxt) begin
            rx_active_d = (bus.ulpi_data_in[5:4] == RXEV_ACTIVE);
            err_d       = (bus.ulpi_data_in[5:4] == RXEV_ERROR);
          end else begin
            valid_d   = 1'b1;
            rx_data_d = bus.ulpi_data_in;
            if (rx_count_q != '1) rx_count_d = rx_count_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Bus outputs follow the next state so they are registered with it.
    case (state_d)
      ST_TX_CMD:  data_out_d = tx_cmd_byte(TX_PID);
      ST_TX_DATA: data_out_d = shift_d[7:0];
      default:    data_out_d = 8'h00;
    endcase
    stp_d = (state_d == ST_TX_STP);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      turn_q      <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      data_out_q  <= 8'h00;
      stp_q       <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      rx_active_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      turn_q      <= turn_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      data_out_q  <= data_out_d;
      stp_q       <= stp_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      rx_active_q <= rx_active_d;
      rx_data_q   <= rx_data_d;
      rx_count_q  <= rx_count_d;
    end
  end

  assign bus.ulpi_data_out = data_out_q;
  assign bus.ulpi_stp      = stp_q;
  assign tx_busy           = busy_q;
  assign tx_done           = done_q;
  assign tx_abort          = abort_q;
  assign rx_valid          = valid_q;
  assign rx_data           = rx_data_q;
  assign rx_active         = rx_active_q;
  assign rx_err            = err_q;
  assign rx_count          = rx_count_q;
endmodule

// File: tb/tb_ulpi_link_ctrl.sv
module tb_ulpi_link_ctrl;
  localparam int TXB = 4;

  logic            clk = 1'b0;
  logic            n_rst;
  logic            tx_start;
  logic [TXB*8-1:0] tx_payload;
  logic            tx_busy, tx_done, tx_abort, rx_valid, rx_active, rx_err;
  logic [7:0]      rx_data;
  logic [9:0]      rx_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done = 0, n_abort = 0, n_valid = 0, n_err = 0, n_stp = 0;
  logic stp_prev = 1'b0;

  ulpi_link_ctrl_if u_if ();

  ulpi_link_ctrl #(.TX_BYTES(TXB), .TX_PID(4'h3), .CNT_W(10)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus        (u_if),
    .tx_start   (tx_start),
    .tx_payload (tx_payload),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_abort   (tx_abort),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_active  (rx_active),
    .rx_err     (rx_err),
    .rx_count   (rx_count)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (tx_done)  n_done++;
    if (tx_abort) n_abort++;
    if (rx_valid) n_valid++;
    if (rx_err)   n_err++;
    if (u_if.ulpi_stp && !stp_prev) n_stp++;
    stp_prev = u_if.ulpi_stp;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One ulpi_clk period: 3 clk high, 3 clk low. Outputs are settled on return.
  task automatic tick();
    u_if.ulpi_clk = 1'b1;
    repeat (3) @(negedge clk);
    u_if.ulpi_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_in(input logic dir, input logic nxt, input logic [7:0] d);
    u_if.ulpi_dir     = dir;
    u_if.ulpi_nxt     = nxt;
    u_if.ulpi_data_in = d;
  endtask

  task automatic start_tx();
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; tx_start = 1'b0; tx_payload = 32'hDDCCBBAA;
    u_if.ulpi_clk = 1'b0;
    bus_in(1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(u_if.ulpi_data_out), 0);
    chk("rst_stp", 32'(u_if.ulpi_stp), 0);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_rx_count", 32'(rx_count), 0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // Test 1: full packet, nxt always high
    start_tx();
    chk("t1_busy", 32'(tx_busy), 1);
    tick();                       chk("t1_cmd", 32'(u_if.ulpi_data_out), 32'h43);
    bus_in(1'b0, 1'b1, 8'h00);
    tick();                       chk("t1_b0", 32'(u_if.ulpi_data_out), 32'hAA);
    tick();                       chk("t1_b1", 32'(u_if.ulpi_data_out), 32'hBB);
    tick();                       chk("t1_b2", 32'(u_if.ulpi_data_out), 32'hCC);
    tick();                       chk("t1_b3", 32'(u_if.ulpi_data_out), 32'hDD);
    tick();                       chk("t1_stp", 32'(u_if.ulpi_stp), 1);
                                  chk("t1_stp_data", 32'(u_if.ulpi_data_out), 0);
    start_tx();                   // ignored: still busy
    tick();                       chk("t1_stp_off", 32'(u_if.ulpi_stp), 0);
                                  chk("t1_done", 32'(n_done), 1);
                                  chk("t1_busy_off", 32'(tx_busy), 0);
    tick();                       chk("t1_ignored_start", 32'(u_if.ulpi_data_out), 0);
                                  chk("t1_stp_once", 32'(n_stp), 1);

    // Test 2: throttle during byte BB
    bus_in(1'b0, 1'b0, 8'h00);
    start_tx();
    tick();                       chk("t2_cmd", 32'(u_if.ulpi_data_out), 32'h43);
    bus_in(1'b0, 1'b1, 8'h00);
    tick();                       chk("t2_b0", 32'(u_if.ulpi_data_out), 32'hAA);
    tick();                       chk("t2_b1", 32'(u_if.ulpi_data_out), 32'hBB);
    bus_in(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();                     chk("t2_hold", 32'(u_if.ulpi_data_out), 32'hBB);
    end
    bus_in(1'b0, 1'b1, 8'h00);
    tick();                       chk("t2_b2", 32'(u_if.ulpi_data_out), 32'hCC);
    tick();                       chk("t2_b3", 32'(u_if.ulpi_data_out), 32'hDD);
    tick();                       chk("t2_stp", 32'(u_if.ulpi_stp), 1);
    tick();                       chk("t2_done", 32'(n_done), 2);

    // Test 4: RX session
    bus_in(1'b1, 1'b0, 8'h00);
    tick();                       chk("t4_turn_data", 32'(u_if.ulpi_data_out), 0);
    bus_in(1'b1, 1'b0, 8'h30);    // turnaround cycle: must be ignored
    tick();                       chk("t4_turn_no_err", 32'(n_err), 0);
    bus_in(1'b1, 1'b0, 8'h10);
    tick();                       chk("t4_active", 32'(rx_active), 1);
    bus_in(1'b1, 1'b1, 8'h5A);
    tick();                       chk("t4_d0", 32'(rx_data), 32'h5A);
    bus_in(1'b1, 1'b1, 8'hA5);
    tick();                       chk("t4_d1", 32'(rx_data), 32'hA5);
                                  chk("t4_valid", 32'(n_valid), 2);
                                  chk("t4_count", 32'(rx_count), 2);
    bus_in(1'b0, 1'b0, 8'h00);
    tick();                       chk("t4_inactive", 32'(rx_active), 0);

    // Test 3: abort after AA accepted; first idle uce after RX is turnaround
    start_tx();
    tick();                       chk("t3_turnaround", 32'(u_if.ulpi_data_out), 0);
    tick();                       chk("t3_cmd", 32'(u_if.ulpi_data_out), 32'h43);
    bus_in(1'b0, 1'b1, 8'h00);
    tick();                       chk("t3_b0", 32'(u_if.ulpi_data_out), 32'hAA);
    tick();                       chk("t3_b1", 32'(u_if.ulpi_data_out), 32'hBB);
    bus_in(1'b1, 1'b0, 8'h00);
    tick();                       chk("t3_abort", 32'(n_abort), 1);
                                  chk("t3_busy", 32'(tx_busy), 0);
                                  chk("t3_data", 32'(u_if.ulpi_data_out), 0);
                                  chk("t3_count_clr", 32'(rx_count), 0);
    bus_in(1'b1, 1'b0, 8'h30);
    tick();                       chk("t3_turn_ignored", 32'(n_err), 0);
    bus_in(1'b1, 1'b0, 8'h10);
    tick();                       chk("t3_rx_bus", 32'(rx_active), 1);
    bus_in(1'b0, 1'b0, 8'h00);
    tick();                       chk("t3_no_stp", 32'(n_stp), 2);
                                  chk("t3_done_unch", 32'(n_done), 2);

    // Test 5: RxError and count saturation
    bus_in(1'b1, 1'b0, 8'h00);
    tick(); tick();
    bus_in(1'b1, 1'b0, 8'h30);
    tick();                       chk("t5_err", 32'(n_err), 1);
                                  chk("t5_not_active", 32'(rx_active), 0);
    bus_in(1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 1022; i++) tick();
    chk("t5_count_1022", 32'(rx_count), 1022);
    for (int i = 0; i < 78; i++) tick();
    chk("t5_count_sat", 32'(rx_count), 1023);
    chk("t5_valid", 32'(n_valid), 1102);
    bus_in(1'b0, 1'b0, 8'h00);
    tick();                       chk("t5_count_hold", 32'(rx_count), 1023);

    // Test 6: async reset mid-packet
    start_tx();
    tick(); tick();               chk("t6_cmd", 32'(u_if.ulpi_data_out), 32'h43);
    bus_in(1'b0, 1'b1, 8'h00);
    tick();                       chk("t6_b0", 32'(u_if.ulpi_data_out), 32'hAA);
    #2 n_rst = 1'b0;
    #1;
    chk("t6_data_out", 32'(u_if.ulpi_data_out), 0);
    chk("t6_busy", 32'(tx_busy), 0);
    chk("t6_rx_count", 32'(rx_count), 0);
    chk("t6_rx_data", 32'(rx_data), 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    tick();                       chk("t6_idle", 32'(u_if.ulpi_data_out), 0);
    start_tx();
    tick();                       chk("t6_restart", 32'(u_if.ulpi_data_out), 32'h43);
    tick();                       chk("t6_restart_b0", 32'(u_if.ulpi_data_out), 32'hAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ulpi_link_ctrl.md
ULPI_LINK_CTRL -- requirements
Module: ulpi_link_ctrl

Interface
REQ-001 Parameter TX_BYTES, default 66, payload bytes per transmit packet (minimum 1).
REQ-002 Parameter TX_PID, default 4'h3, PID nibble placed in the TX CMD byte.
REQ-003 Parameter CNT_W, default 10, width of the RX byte counter.
REQ-004 clk  input  1  system clock; reset n_rst, asynchronous, active-low; clock clk.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 ulpi_clk  input  1  PHY 60 MHz clock, sampled on clk.
REQ-007 ulpi_dir  input  1  PHY bus-ownership indicator.
REQ-008 ulpi_nxt  input  1  PHY throttle/data-valid indicator.
REQ-009 ulpi_data_in  input  8  bus data from the PHY.
REQ-010 ulpi_data_out  output  8  bus data to the PHY.
REQ-011 ulpi_stp  output  1  end-of-packet strobe.
REQ-012 tx_start  input  1  one-clk request to send tx_payload.
REQ-013 tx_payload  input  TX_BYTES*8  packet, byte 0 in bits [7:0].
REQ-014 tx_busy  output  1  high from accepted request until done or abort.
REQ-015 tx_done / tx_abort  output  1 each  one-clk completion / abort pulses.
REQ-016 rx_valid  output  1  one-clk pulse qualifying rx_data.
REQ-017 rx_data  output  8  received byte.
REQ-018 rx_active / rx_err  output  1 each  RxActive level / RxError one-clk pulse.
REQ-019 rx_count  output  CNT_W  bytes received in the current RX session, saturating.

Function
REQ-020 The block SHALL detect a ulpi_clk rising edge (uce) as a registered 0->1 of the sampled signal; every bus action below SHALL occur only in the clk cycle where uce=1.
REQ-021 States SHALL be IDLE, TX_CMD, TX_DATA, TX_STP, RX_TURN, RX_BUS.
REQ-022 tx_start SHALL be latched as pending only when tx_busy=0; tx_start while busy SHALL be ignored.
REQ-023 IDLE: ulpi_dir=1 SHALL go to RX_TURN, taking priority over a pending TX; else pending and uce SHALL go to TX_CMD, load tx_payload into the shift register, and clear the byte index.
REQ-024 TX_CMD: ulpi_data_out SHALL be {2'b01,2'b00,TX_PID}; uce with ulpi_nxt=1 SHALL go to TX_DATA.
REQ-025 TX_DATA: ulpi_data_out SHALL be shift[7:0]; uce with ulpi_nxt=1 SHALL shift right 8 bits and increment the index; acceptance at index TX_BYTES-1 SHALL go to TX_STP; ulpi_nxt=0 SHALL hold the byte.
REQ-026 TX_STP: ulpi_stp=1 and ulpi_data_out=0 until the next uce, then IDLE with a one-clk tx_done pulse.
REQ-027 ulpi_dir=1 in TX_CMD or TX_DATA SHALL pulse tx_abort, drop tx_busy, suppress ulpi_stp, and go to RX_TURN.
REQ-028 RX_TURN: the first uce SHALL be a turnaround cycle with data ignored, then go to RX_BUS; ulpi_dir=0 before that SHALL return to IDLE.
REQ-029 RX_BUS, uce, dir=1, nxt=0: rx_active <= (data_in[5:4]==2'b01); data_in[5:4]==2'b11 SHALL pulse rx_err.
REQ-030 RX_BUS, uce, dir=1, nxt=1: rx_valid SHALL pulse, rx_data <= data_in, and rx_count SHALL increment, saturating at all-ones.
REQ-031 RX_BUS with ulpi_dir=0 SHALL go to IDLE, clear rx_active, and take one turnaround uce before any TX; rx_count SHALL clear on entry to RX_TURN.
REQ-032 Outside TX states, ulpi_data_out SHALL be 8'h00 and ulpi_stp SHALL be 0.

Reset
REQ-033 n_rst low SHALL force IDLE, clear pending, shift register, index and rx_count, and drive every output to 0, mid-packet included.

Structure
REQ-034 Package ulpi_pkg SHALL hold the state enum, the TX CMD prefix 2'b01 and the RX CMD LineState/RxEvent encodings.
REQ-035 Sub-module ulpi_edge_sync SHALL perform the ulpi_clk sampling and rising-edge detection.

Verification (TX_BYTES=4)
REQ-036 Test 1: tx_payload=32'hDDCCBBAA, nxt=1 -> data_out 8'h43, AA, BB, CC, DD on successive uce; stp for one uce; tx_done pulses once.
REQ-037 Test 2: nxt=0 for 3 uce during byte BB -> BB held for 3 uce, then the sequence resumes unchanged.
REQ-038 Test 3: dir rises after AA is accepted -> tx_abort pulses, stp never asserts, state goes to RX_TURN.
REQ-039 Test 4: dir=1, then RXCMD 8'h10, data 8'h5A and 8'hA5 with nxt=1 -> rx_active=1, two rx_valid pulses, rx_count=2.
REQ-040 Test 5: RXCMD 8'h30 -> rx_err pulses; 1100 bytes received -> rx_count saturates at 1023.
REQ-041 Test 6: n_rst asserted during TX_DATA -> all outputs 0 asynchronously; IDLE after release.
